// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract engine: operands stream LSB-first through one
// gate-level full adder, with valid/ready handshakes on input and result.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic ab_x;
    logic ab_a;
    logic c_a;

    xor u_x0 (ab_x, a, b);
    xor u_x1 (s, ab_x, cin);
    and u_a0 (ab_a, a, b);
    and u_a1 (c_a, ab_x, cin);
    or  u_o0 (cout, ab_a, c_a);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;
    logic             ovf_q;
    logic             fa_s;
    logic             fa_cout;
    logic             last_bit;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (last_bit) state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Result registers are captured on the final RUN edge so they stay put
    // through the next operation until it completes; carry into the MSB is
    // the carry flop's value on that same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res     <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sh  <= op_a;
                        b_sh  <= sub ? ~op_b : op_b;
                        carry <= sub ? 1'b1 : c_in;
                        cnt   <= '0;
                    end
                end
                S_RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    res   <= {fa_s, res[WIDTH-1:1]};
                    carry <= fa_cout;
                    if (last_bit) begin
                        sum_q   <= {fa_s, res[WIDTH-1:1]};
                        c_out_q <= fa_cout;
                        ovf_q   <= carry ^ fa_cout;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum      = sum_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial add/subtract engine built around one instance of the team's gate-level one-bit full adder. It accepts two WIDTH-bit operands over a valid/ready handshake and feeds them LSB-first through the single full adder, one bit per clock, with the carry held in a flop. It then presents the WIDTH-bit result, carry-out and signed overflow on a second valid/ready handshake. It is the area-minimal adder option for slow FIR coefficient/accumulator paths where a WIDTH-bit ripple-carry adder is not justified.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), width of the internal bit counter; derived, not overridden.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept operands (IDLE only).
- op_a  input  WIDTH  operand A, two's complement or unsigned.
- op_b  input  WIDTH  operand B.
- c_in  input  1  carry-in for add mode; ignored when sub=1.
- sub  input  1  1 = A - B, 0 = A + B + c_in.
- out_valid  output  1  result registers hold a completed operation.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result (A+B+c_in or A-B), modulo 2^WIDTH.
- c_out  output  1  carry out of MSB; in sub mode 1 = no borrow.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- busy  output  1  high in RUN and DONE.

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; sum=0; c_out=0; overflow=0; busy=0; shift registers, carry flop and counter cleared. Reset mid-operation aborts the operation and produces no output.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On an edge with in_valid=1:
  - a_sh <= op_a
  - b_sh <= sub ? ~op_b : op_b
  - carry <= sub ? 1 : c_in
  - cnt <= 0; state <= RUN
  - op_a, op_b, c_in and sub are sampled only on this edge.
- RUN: in_ready=0. Each edge:
  - The full adder sees a_sh[0], b_sh[0], carry.
  - Its sum bit shifts into res[WIDTH-1] while res shifts right.
  - a_sh and b_sh shift right; carry <= adder c_out.
  - When cnt==WIDTH-1, msb_cin <= carry (pre-update value) and state <= DONE; otherwise cnt++.
- DONE: out_valid=1.
  - sum=res; c_out=carry; overflow=msb_cin^carry.
  - Outputs are stable while out_ready=0, with unlimited backpressure.
  - On an edge with out_ready=1: state <= IDLE, out_valid <= 0. The sum, c_out and overflow registers keep their last values.
- Latency: the acceptance edge is E0, and RUN occupies edges E1..E_WIDTH. out_valid is high in the cycle after E_WIDTH, i.e. WIDTH+1 edges after E0 inclusive.
- Throughput: one operation per WIDTH+2 cycles minimum. There is no same-cycle overlap: in_ready rises the cycle after the result handshake.
- in_valid during RUN/DONE is ignored, not queued; the producer must hold it until in_ready.
- out_ready in IDLE/RUN has no effect.
- Arithmetic is modulo 2^WIDTH.
- c_out and overflow are meaningful for both modes: unsigned and signed respectively.
- busy = (state != IDLE).

Test Plan:
- WIDTH=8, A=0x5A, B=0x3C, sub=0, c_in=0, out_ready=1 -> out_valid exactly 9 edges after acceptance; sum=0x96, c_out=0, overflow=1.
- A=0xFF, B=0x01, sub=0, c_in=0 -> sum=0x00, c_out=1, overflow=0. A=0x00, B=0x00, c_in=1 -> sum=0x01, c_out=0, overflow=0.
- Subtract: A=0x10, B=0x20 -> sum=0xF0, c_out=0, overflow=0. A=0x80, B=0x01 -> sum=0x7F, c_out=1, overflow=1. c_in=1 in sub mode is ignored: result unchanged.
- Backpressure: A=0x33, B=0x11 with out_ready held 0 for 5 cycles in DONE -> sum=0x44 stable, out_valid=1, in_ready=0 throughout. After out_ready=1, out_valid=0 next cycle and in_ready=1.
- Back-to-back: in_valid held high with 3 different operand pairs -> each accepted only when in_ready=1, results in order, and new operands driven during RUN do not corrupt the result.
- Reset mid-RUN: assert rst asynchronously after 3 RUN edges -> outputs go to 0 and in_ready=1 immediately, with no out_valid pulse. A following A=0x01, B=0x01 gives sum=0x02.
